// File: rtl/regfile_mp_pkg.sv
// Shared defaults and index helpers for the multi-port register file.
// The PC sits at the top architectural index; the helpers locate it and the packed port slices.
package regfile_mp_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 16;
    localparam int AW_DEF   = 4;
    localparam int NRD_DEF  = 3;

    function automatic int pc_index(input int nreg);
        return nreg - 1;
    endfunction

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port: PC override, W1/W0 write-through bypass and hazard flag.
module regfile_mp_rdport
    import regfile_mp_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic [AW-1:0] ra,
    input  logic [DW-1:0] pc_plus8,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    input  logic [DW-1:0] stored,
    input  logic          busy_bit,
    output logic [DW-1:0] rd,
    output logic          rd_busy
);

    localparam logic [AW:0] NREG_X = (AW+1)'(NREG);
    localparam logic [AW:0] PC_X   = (AW+1)'(pc_index(NREG));

    logic in_range;
    logic is_pc;
    logic hit1;
    logic hit0;

    assign in_range = {1'b0, ra} < NREG_X;
    assign is_pc    = {1'b0, ra} == PC_X;
    assign hit1     = we1 && (wa1 == ra);
    assign hit0     = we0 && (wa0 == ra);

    // W1 is checked before W0 so the bypass agrees with the collision rule on the stored value.
    always_comb begin
        rd      = '0;
        rd_busy = 1'b0;
        if (is_pc) begin
            rd = pc_plus8;
        end else if (in_range) begin
            if (hit1) begin
                rd = wd1;
            end else if (hit0) begin
                rd = wd0;
            end else begin
                rd = stored;
            end
            rd_busy = busy_bit && !hit1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD bypassed read ports, ALU (W0) and load (W1) write ports,
// per-register load scoreboard, and a PC slot that reads pc_plus8 and rejects writes.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int NRD  = NRD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic [DW-1:0]     pc_plus8,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic              lock_en,
    input  logic [AW-1:0]     lock_addr,
    output logic [NREG-1:0]   busy,
    output logic              pc_wr_err
);

    localparam int          PC   = pc_index(NREG);
    localparam logic [AW:0] PC_X = (AW+1)'(PC);

    // True for general-purpose registers only; excludes the PC and unpopulated addresses.
    function automatic logic is_gpr(input logic [AW-1:0] a);
        return {1'b0, a} < PC_X;
    endfunction

    logic [DW-1:0]   regs_q [PC];
    logic [DW-1:0]   regs_d [PC];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            pc_wr_err_q;
    logic            pc_wr_err_d;

    always_comb begin
        regs_d = regs_q;
        if (we0 && is_gpr(wa0)) begin
            regs_d[wa0] = wd0;
        end
        if (we1 && is_gpr(wa1)) begin
            regs_d[wa1] = wd1;
        end
    end

    // Lock is applied after the W1 clear so a back-to-back load to the same register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (we1 && is_gpr(wa1)) begin
            busy_d[wa1] = 1'b0;
        end
        if (lock_en && is_gpr(lock_addr)) begin
            busy_d[lock_addr] = 1'b1;
        end
        busy_d[PC] = 1'b0;
    end

    always_comb begin
        pc_wr_err_d = (we0 && ({1'b0, wa0} == PC_X)) || (we1 && ({1'b0, wa1} == PC_X));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            pc_wr_err_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            pc_wr_err_q <= pc_wr_err_d;
        end
    end

    assign busy      = busy_q;
    assign pc_wr_err = pc_wr_err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        logic [DW-1:0] stored_k;
        logic          busy_k;

        assign ra_k = ra[slice_lo(k, AW) +: AW];

        always_comb begin
            stored_k = '0;
            busy_k   = 1'b0;
            if (is_gpr(ra_k)) begin
                stored_k = regs_q[ra_k];
                busy_k   = busy_q[ra_k];
            end
        end

        regfile_mp_rdport #(
            .DW   (DW),
            .AW   (AW),
            .NREG (NREG)
        ) u_rdport (
            .ra       (ra_k),
            .pc_plus8 (pc_plus8),
            .we0      (we0),
            .wa0      (wa0),
            .wd0      (wd0),
            .we1      (we1),
            .wa1      (wa1),
            .wd1      (wd1),
            .stored   (stored_k),
            .busy_bit (busy_k),
            .rd       (rd[slice_lo(k, DW) +: DW]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expectations are queued as stimulus is applied and
// popped against the DUT outputs once they have settled.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NRD = 3;
    localparam int NREG = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rd_busy;
    logic [DW-1:0]     pc_plus8;
    logic              we0, we1, lock_en;
    logic [AW-1:0]     wa0, wa1, lock_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [NREG-1:0]   busy;
    logic              pc_wr_err;

    regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .pc_plus8  (pc_plus8),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy      (busy),
        .pc_wr_err (pc_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] rd_port(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic idle_writes();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        lock_en = 1'b0; lock_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pc_plus8 = 32'h0000_0108;
        idle_writes();
        set_ra(4'd0, 4'd1, 4'd2);
        #2;
        expect_val("reset_busy", 32'h0);
        check({16'h0, busy});
        expect_val("reset_rd0", 32'h0);
        check(rd_port(0));
        expect_val("reset_pc_wr_err", 32'h0);
        check({31'h0, pc_wr_err});

        tick();
        rst_n = 1'b1;
        tick();

        // W0 write with same-cycle bypass, then stored value
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEAD_BEEF;
        set_ra(4'd3, 4'd1, 4'd2);
        #1;
        expect_val("bypass_w0", 32'hDEAD_BEEF);
        check(rd_port(0));
        tick();
        idle_writes();
        #1;
        expect_val("stored_r3", 32'hDEAD_BEEF);
        check(rd_port(0));

        // Collision: W1 wins
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22;
        set_ra(4'd3, 4'd5, 4'd2);
        #1;
        expect_val("collision_bypass", 32'h22);
        check(rd_port(1));
        tick();
        idle_writes();
        #1;
        expect_val("collision_stored", 32'h22);
        check(rd_port(1));

        // PC reads and write rejection
        set_ra(4'd3, 4'd5, 4'd15);
        #1;
        expect_val("pc_read", 32'h108);
        check(rd_port(2));
        we0 = 1'b1; wa0 = 4'd15; wd0 = 32'hCAFE_0001;
        #1;
        expect_val("pc_read_during_write", 32'h108);
        check(rd_port(2));
        expect_val("pc_wr_err_not_yet", 32'h0);
        check({31'h0, pc_wr_err});
        tick();
        idle_writes();
        #1;
        expect_val("pc_wr_err_set", 32'h1);
        check({31'h0, pc_wr_err});
        expect_val("pc_read_after", 32'h108);
        check(rd_port(2));
        tick();
        expect_val("pc_wr_err_one_cycle", 32'h0);
        check({31'h0, pc_wr_err});
        expect_val("r3_untouched", 32'hDEAD_BEEF);
        check(rd_port(0));

        // Scoreboard lock
        lock_en = 1'b1; lock_addr = 4'd7;
        set_ra(4'd7, 4'd5, 4'd15);
        tick();
        idle_writes();
        #1;
        expect_val("busy_after_lock", 32'h0080);
        check({16'h0, busy});
        expect_val("rd_busy_locked", 32'b001);
        check({29'h0, rd_busy});

        // Load completes: bypass clears hazard same cycle
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h55;
        #1;
        expect_val("rd_busy_w1_bypass", 32'b000);
        check({29'h0, rd_busy});
        expect_val("rd_w1_bypass", 32'h55);
        check(rd_port(0));
        expect_val("busy_still_set", 32'h0080);
        check({16'h0, busy});
        tick();
        idle_writes();
        #1;
        expect_val("busy_cleared", 32'h0);
        check({16'h0, busy});
        expect_val("r7_stored", 32'h55);
        check(rd_port(0));

        // Lock/clear race: set wins
        lock_en = 1'b1; lock_addr = 4'd7;
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h66;
        tick();
        idle_writes();
        #1;
        expect_val("race_busy", 32'h0080);
        check({16'h0, busy});
        expect_val("race_data", 32'h66);
        check(rd_port(0));

        // W0 does not touch busy nor hide the hazard
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h77;
        #1;
        expect_val("rd_busy_w0_no_clear", 32'b001);
        check({29'h0, rd_busy});
        tick();
        idle_writes();
        #1;
        expect_val("busy_after_w0", 32'h0080);
        check({16'h0, busy});
        expect_val("r7_w0_data", 32'h77);
        check(rd_port(0));

        // Locking the PC index is ignored
        lock_en = 1'b1; lock_addr = 4'd15;
        tick();
        idle_writes();
        #1;
        expect_val("pc_lock_ignored", 32'h0080);
        check({16'h0, busy});
        expect_val("rd_busy_pc_port", 32'b001);
        check({29'h0, rd_busy});

        // Asynchronous reset mid-run, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_busy", 32'h0);
        check({16'h0, busy});
        for (int i = 0; i < NREG - 1; i++) begin
            set_ra(AW'(i), 4'd15, 4'd15);
            #1;
            expect_val($sformatf("async_r%0d", i), 32'h0);
            check(rd_port(0));
        end
        expect_val("async_rd_busy", 32'h0);
        check({29'h0, rd_busy});

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
